// File: rtl/dsky_tx_framer.sv
// DSKY display downstream framer: shadows VERB/NOUN/PROG writes and serializes each
// changed register as a 5-byte ASCII frame ('>', tag, two octal digits, CR) over valid/ready.
module dsky_tx_framer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        disp_write_en,
  input  logic [1:0]  disp_write_sel,
  input  logic [14:0] disp_write_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  localparam int unsigned DIGIT_W  = 6;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned NUM_REGS = 3;
  localparam int unsigned SEL_W    = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(4);

  localparam logic [SEL_W-1:0] SEL_VERB = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_NOUN = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_PROG = SEL_W'(2);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     byte_idx, idx_nxt;
  logic [DIGIT_W-1:0]   frame_val, fval_nxt;
  logic [SEL_W-1:0]     frame_sel, fsel_nxt;
  logic [DIGIT_W-1:0]   shadow_v, shadow_n, shadow_p;
  logic [NUM_REGS-1:0]  dirty, dirty_nxt, dirty_clr, wr_set;
  logic [BYTE_W-1:0]    tx_data_nxt;
  logic                 busy_nxt;

  // Only the two octal digits of the AGC word are displayed.
  logic unused_upper;
  assign unused_upper = ^disp_write_data[14:DIGIT_W];

  function automatic logic [BYTE_W-1:0] frame_byte(input logic [SEL_W-1:0]   sel,
                                                   input logic [DIGIT_W-1:0] val,
                                                   input logic [IDX_W-1:0]   idx);
    logic [BYTE_W-1:0] tag;
    case (sel)
      SEL_VERB: tag = 8'h56;
      SEL_NOUN: tag = 8'h4E;
      default:  tag = 8'h50;
    endcase
    case (idx)
      IDX_W'(0): frame_byte = 8'h3E;
      IDX_W'(1): frame_byte = tag;
      IDX_W'(2): frame_byte = 8'h30 | BYTE_W'(val[5:3]);
      IDX_W'(3): frame_byte = 8'h30 | BYTE_W'(val[2:0]);
      IDX_W'(4): frame_byte = 8'h0D;
      default:   frame_byte = 8'h00;
    endcase
  endfunction

  // Next-state, arbitration and registered-output precompute.
  always_comb begin
    state_nxt = state;
    idx_nxt   = byte_idx;
    fval_nxt  = frame_val;
    fsel_nxt  = frame_sel;
    dirty_clr = '0;
    wr_set    = '0;

    case (state)
      ST_IDLE: begin
        if (|dirty) begin
          state_nxt = ST_SEND;
          idx_nxt   = '0;
          if (dirty[0]) begin
            fsel_nxt  = SEL_VERB;
            fval_nxt  = shadow_v;
            dirty_clr = 3'b001;
          end else if (dirty[1]) begin
            fsel_nxt  = SEL_NOUN;
            fval_nxt  = shadow_n;
            dirty_clr = 3'b010;
          end else begin
            fsel_nxt  = SEL_PROG;
            fval_nxt  = shadow_p;
            dirty_clr = 3'b100;
          end
        end
      end
      ST_SEND: begin
        if (tx_valid && tx_ready) begin
          if (byte_idx == LAST_IDX) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = byte_idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (disp_write_en) begin
      case (disp_write_sel)
        SEL_VERB: wr_set = 3'b001;
        SEL_NOUN: wr_set = 3'b010;
        SEL_PROG: wr_set = 3'b100;
        default:  wr_set = '0;
      endcase
    end

    // A write in the same cycle as arbitration re-arms the register.
    dirty_nxt   = (dirty & ~dirty_clr) | wr_set;
    busy_nxt    = (state_nxt == ST_SEND) | (|dirty_nxt);
    tx_data_nxt = (state_nxt == ST_SEND) ? frame_byte(fsel_nxt, fval_nxt, idx_nxt) : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      byte_idx  <= '0;
      frame_val <= '0;
      frame_sel <= '0;
      dirty     <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      byte_idx  <= idx_nxt;
      frame_val <= fval_nxt;
      frame_sel <= fsel_nxt;
      dirty     <= dirty_nxt;
      tx_valid  <= (state_nxt == ST_SEND);
      tx_data   <= tx_data_nxt;
      busy      <= busy_nxt;
    end
  end

  // Latest-value shadows.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_v <= '0;
      shadow_n <= '0;
      shadow_p <= '0;
    end else if (disp_write_en) begin
      case (disp_write_sel)
        SEL_VERB: shadow_v <= disp_write_data[DIGIT_W-1:0];
        SEL_NOUN: shadow_n <= disp_write_data[DIGIT_W-1:0];
        SEL_PROG: shadow_p <= disp_write_data[DIGIT_W-1:0];
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsky_tx_framer.sv
// Bench for dsky_tx_framer: transaction-level frame model checked every cycle,
// plus literal byte sequences for each directed scenario.
module tb_dsky_tx_framer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        disp_write_en = 1'b0;
  logic [1:0]  disp_write_sel = 2'd0;
  logic [14:0] disp_write_data = 15'd0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;

  dsky_tx_framer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .disp_write_en  (disp_write_en),
    .disp_write_sel (disp_write_sel),
    .disp_write_data(disp_write_data),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: shadows, dirty flags and the bytes of the frame in flight.
  logic [5:0] m_shadow [3];
  logic       m_dirty  [3];
  logic [7:0] m_q [$];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int         ready_mode = 0;  // 0: always ready, 1: toggle, 2: never ready

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] tag_of(input int s);
    case (s)
      0: return 8'h56;
      1: return 8'h4E;
      default: return 8'h50;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin m_shadow[i] = '0; m_dirty[i] = 1'b0; end
  end

  // Model update on each clock edge / async reset.
  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      m_q.delete();
      for (int i = 0; i < 3; i++) begin m_shadow[i] = '0; m_dirty[i] = 1'b0; end
    end else begin
      if (m_q.size() != 0) begin
        if (tx_ready) void'(m_q.pop_front());
      end else begin
        int s;
        s = m_dirty[0] ? 0 : m_dirty[1] ? 1 : m_dirty[2] ? 2 : -1;
        if (s >= 0) begin
          m_q.push_back(8'h3E);
          m_q.push_back(tag_of(s));
          m_q.push_back(8'h30 + 8'(m_shadow[s][5:3]));
          m_q.push_back(8'h30 + 8'(m_shadow[s][2:0]));
          m_q.push_back(8'h0D);
          m_dirty[s] = 1'b0;
        end
      end
      if (disp_write_en && disp_write_sel != 2'd3) begin
        m_shadow[disp_write_sel] = disp_write_data[5:0];
        m_dirty[disp_write_sel]  = 1'b1;
      end
    end
  end

  // Per-cycle compare and handshake monitor.
  initial forever begin
    logic ev, eb;
    @(negedge clock);
    ev = (m_q.size() != 0);
    eb = ev | m_dirty[0] | m_dirty[1] | m_dirty[2];
    chk("tx_valid", 32'(tx_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(eb));
    if (ev) chk("tx_data", 32'(tx_data), 32'(m_q[0]));
    if (!reset_n) chk("tx_data_rst", 32'(tx_data), 32'h0);
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
  end

  // tx_ready driver, changes just after the rising edge.
  initial forever begin
    @(posedge clock);
    #1;
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ~tx_ready;
      default: tx_ready = 1'b0;
    endcase
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [1:0] sel, input logic [14:0] data);
    disp_write_en   = 1'b1;
    disp_write_sel  = sel;
    disp_write_data = data;
    step();
    disp_write_en   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || tx_valid) && n < 300) begin step(); n++; end
    chk({name, "_timeout"}, 32'(n < 300), 32'd1);
  endtask

  task automatic check_seq(input string name);
    chk({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_b%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(tx_data), 32'h00);
    reset_n = 1'b1;
    step();
    got_q.delete();

    // Single VERB frame, ready held high; first byte 2 cycles after the strobe.
    do_write(2'd0, 15'o37);
    chk("t1_valid_k", 32'(tx_valid), 32'd0);
    chk("t1_busy_k", 32'(busy), 32'd1);
    step();
    chk("t1_valid_k1", 32'(tx_valid), 32'd1);
    chk("t1_first", 32'(tx_data), 32'h3E);
    wait_idle("t1");
    exp_q = '{8'h3E, 8'h56, 8'h33, 8'h37, 8'h0D};
    check_seq("t1");

    // Same frame with ready toggling every cycle.
    ready_mode = 1;
    do_write(2'd0, 15'o37);
    wait_idle("t2");
    ready_mode = 0;
    step();
    exp_q = '{8'h3E, 8'h56, 8'h33, 8'h37, 8'h0D};
    check_seq("t2");

    // Three registers dirty together while a stalled frame holds the link.
    ready_mode = 2;
    step();
    do_write(2'd0, 15'o11);
    step();
    do_write(2'd1, 15'o16);
    do_write(2'd2, 15'o63);
    do_write(2'd0, 15'o06);
    repeat (3) step();
    chk("t3_stall_data", 32'(tx_data), 32'h3E);
    ready_mode = 0;
    wait_idle("t3");
    exp_q = '{8'h3E, 8'h56, 8'h31, 8'h31, 8'h0D,
              8'h3E, 8'h56, 8'h30, 8'h36, 8'h0D,
              8'h3E, 8'h4E, 8'h31, 8'h36, 8'h0D,
              8'h3E, 8'h50, 8'h36, 8'h33, 8'h0D};
    check_seq("t3");

    // Writes to VERB during its own frame coalesce into one follow-up frame.
    do_write(2'd0, 15'o37);
    step();
    do_write(2'd0, 15'o21);
    do_write(2'd0, 15'o22);
    wait_idle("t4");
    exp_q = '{8'h3E, 8'h56, 8'h33, 8'h37, 8'h0D,
              8'h3E, 8'h56, 8'h32, 8'h32, 8'h0D};
    check_seq("t4");

    // sel=3 ignored; upper data bits ignored.
    do_write(2'd3, 15'o77);
    repeat (5) begin
      chk("t5_busy", 32'(busy), 32'd0);
      step();
    end
    exp_q.delete();
    check_seq("t5a");
    do_write(2'd1, 15'o77777);
    wait_idle("t5");
    exp_q = '{8'h3E, 8'h4E, 8'h37, 8'h37, 8'h0D};
    check_seq("t5b");

    // Reset mid-frame with NOUN pending: frame aborted, nothing after release.
    do_write(2'd0, 15'o37);
    do_write(2'd1, 15'o05);
    step();
    step();
    chk("t6_byte2", 32'(tx_data), 32'h33);
    exp_q = '{8'h3E, 8'h56};
    check_seq("t6_pre");
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(tx_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    got_q.delete();
    repeat (20) step();
    chk("t6_post_busy", 32'(busy), 32'd0);
    exp_q.delete();
    check_seq("t6_post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dsky_tx_framer.md
# dsky_tx_framer

Downstream DSKY display path of the IO unit. Accepts display-register writes from the core (VERB, NOUN, PROG), keeps a latest-value shadow and a dirty flag per register, and serializes each changed register as a 5-byte ASCII frame into the UART transmitter over a valid/ready byte handshake. Repeated writes to one register coalesce, so a write is never blocked and the core never stalls on display traffic.

## Interface
- No parameters; frame format and register set are fixed.
- clock  input  1  system clock; all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- disp_write_en  input  1  display write strobe, one write per asserted cycle
- disp_write_sel  input  2  0=VERB, 1=NOUN, 2=PROG, 3=ignored
- disp_write_data  input  15  AGC word; only bits [5:0] (two octal digits) used
- tx_data  output  8  byte to UART transmitter
- tx_valid  output  1  tx_data holds a byte to send
- tx_ready  input  1  transmitter accepts tx_data this cycle
- busy  output  1  frame in progress or any register dirty

## Operation
- Shadow regs shadow_V/N/P [5:0], dirty bits dirty_V/N/P.
- Write (disp_write_en=1, sel 0..2): shadow[sel] <= data[5:0], dirty[sel] <= 1. sel=3: no effect.
- Frame bytes, in order: 0x3E '>', tag ('V'=0x56, 'N'=0x4E, 'P'=0x50), '0'+d[5:3], '0'+d[2:0], 0x0D.
- FSM states: IDLE, SEND.
  - IDLE: if any dirty, pick fixed priority V > N > P; copy shadow to frame_val, latch tag, clear that dirty bit, byte_idx <= 0, go SEND. Else stay.
  - SEND: tx_valid=1, tx_data = frame byte[byte_idx]. On tx_valid && tx_ready: byte_idx==4 -> IDLE, else byte_idx+1.
- Snapshot: frame content fixed at IDLE→SEND; later writes to same register do not alter frame in flight, they set dirty again -> new frame after current one.
- Simultaneous write and dirty-clear of same register on IDLE→SEND edge: write wins, dirty stays 1, shadow takes new value; frame in flight carries old value.
- Coalescing: multiple writes to one register while dirty -> one frame with last value.
- busy = (state==SEND) | dirty_V | dirty_N | dirty_P.

## Timing
- Reset (async assert, sync-free release): state=IDLE, byte_idx=0, tx_valid=0, tx_data=0x00, busy=0, all shadows 0, all dirty 0. Reset mid-frame aborts frame; no partial completion after release.
- Write sampled at edge k -> dirty visible after edge k; IDLE→SEND at edge k+1; tx_valid=1 and tx_data=0x3E after edge k+1 (2-cycle latency from write strobe).
- tx_data and tx_valid are registered; stable while tx_valid=1 and tx_ready=0 (no retraction, no change).
- With tx_ready held 1: one byte per cycle, 5 cycles per frame.
- After final byte handshake: one IDLE cycle with tx_valid=0 before next frame's first byte.
- Back-to-back dirty registers: frames separated by exactly one idle cycle.

## Test plan
- Reset, write sel=0 data=15'o37, tx_ready=1 -> bytes 0x3E,0x56,0x33,0x37,0x0D on consecutive cycles starting 2 cycles after write; busy falls after last byte.
- Same write with tx_ready toggled 1/0 every cycle -> identical 5-byte sequence, tx_data held constant during every ready=0 cycle, no byte duplicated or skipped.
- Write NOUN=15'o16 then PROG=15'o63 then VERB=15'o06 in one IDLE window before arbitration completes -> frames V(0x30,0x36), N(0x31,0x36), P(0x36,0x33) in that order, one idle cycle between.
- During VERB=15'o37 frame, write VERB=15'o21 then 15'o22 -> current frame completes with 0x33,0x37; exactly one further V frame with 0x32,0x32.
- Write sel=3 data=15'o77 -> no tx_valid, busy stays 0; write data=15'o77777 sel=1 -> digits 0x37,0x37 (upper bits ignored).
- Assert reset_n=0 at byte 2 of a frame with NOUN also dirty -> tx_valid=0 immediately, after release no frames emitted, busy=0.
